// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the ONC-16 serial receive path:
//   - receive FSM and mailbox FSM state encodings
//   - RX status word bit indices
//   - default data-RAM addresses of the UART mailbox words
//   - helper that assembles the RX status word
// Optional macro: UART_RX_PARITY_EN (adds the PARITY receive state, 8E1).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_RX_PARITY_EN
        R_PARITY,
`endif
        R_STOP
    } rx_state_e;

    // M_WAIT is the one-cycle hold used when the CPU acknowledges in the
    // same cycle the status write would be scheduled.
    typedef enum logic [1:0] {
        M_IDLE,
        M_DATA,
        M_WAIT,
        M_STAT
    } mb_state_e;

    localparam int ST_VALID = 0;
    localparam int ST_OVR   = 1;
    localparam int ST_FERR  = 2;
    localparam int ST_PERR  = 3;

    localparam logic [11:0] ADDR_TX_DATA   = 12'h800;
    localparam logic [11:0] ADDR_TX_STATUS = 12'h801;
    localparam logic [11:0] ADDR_RX_STATUS = 12'h802;
    localparam logic [11:0] ADDR_RX_DATA   = 12'h803;

    function automatic logic [15:0] rx_status_word(input logic perr,
                                                   input logic ferr,
                                                   input logic ovr);
        logic [15:0] w;
        w           = '0;
        w[ST_VALID] = 1'b1;
        w[ST_OVR]   = ovr;
        w[ST_FERR]  = ferr;
        w[ST_PERR]  = perr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_rx_bridge_if
// Bus bundle between the receive bridge, the CPU data-memory port (snooped
// for the status acknowledge) and port 2 of the shared data RAM.
//   cpu_addr / cpu_we : CPU port-1 address and write enable (observed)
//   mem_addr / mem_din / mem_we : RAM port-2 write channel (driven by bridge)
// master = bridge side, slave = CPU/RAM side.
// ---------------------------------------------------------------------------
interface uart_rx_bridge_if;
    logic [11:0] cpu_addr;
    logic        cpu_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;

    modport master (
        input  cpu_addr, cpu_we,
        output mem_addr, mem_din, mem_we
    );

    modport slave (
        output cpu_addr, cpu_we,
        input  mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Line synchronizer, baud counter and receive FSM.
//   clock     : system clock, rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   byte_done : one-cycle pulse after the stop bit has been sampled
//   data      : received byte, valid with byte_done
//   stop_ok   : sampled stop bit of the last frame
//   par_ok    : even parity matched (tied high when parity is disabled)
// Optional macro: UART_RX_PARITY_EN (8E1 frames, PARITY state).
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR = 434
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_done,
    output logic [7:0] data,
    output logic       stop_ok,
    output logic       par_ok
);
    localparam int CW = $clog2(DIVISOR + 1);
    localparam logic [CW-1:0] BIT_RELOAD = CW'(DIVISOR - 1);
    // Edge detect and FSM entry cost two cycles beyond the synchronizer, so
    // the start sample lands 2 + DIVISOR/2 cycles after the line fell.
    localparam logic [CW-1:0] START_LOAD = CW'(DIVISOR / 2 - 2);

    logic          sync1_q, sync2_q, prev_q;
    logic          fall;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          done_q, stop_ok_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;

`ifdef UART_RX_PARITY_EN
    logic par_ok_q;
    assign par_ok = par_ok_q;
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            stop_ok_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_ok_q  <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (fall) begin
                        state_q <= R_START;
                        cnt_q   <= START_LOAD;
                    end
                end
                R_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!sync2_q) begin
                        state_q <= R_DATA;
                        cnt_q   <= BIT_RELOAD;
                        bit_q   <= '0;
                    end else begin
                        state_q <= R_IDLE;   // line back high: glitch
                    end
                end
                R_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        shift_q <= {sync2_q, shift_q[7:1]};   // LSB first
                        bit_q   <= bit_q + 3'd1;
                        cnt_q   <= BIT_RELOAD;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= R_PARITY;
`else
                            state_q <= R_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                R_PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        par_ok_q <= (sync2_q == ^shift_q);
                        cnt_q    <= BIT_RELOAD;
                        state_q  <= R_STOP;
                    end
                end
`endif
                R_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        stop_ok_q <= sync2_q;
                        done_q    <= 1'b1;
                        state_q   <= R_IDLE;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign byte_done = done_q;
    assign data      = shift_q;
    assign stop_ok   = stop_ok_q;

endmodule

// File: rtl/uart_rx_bridge.sv
// ---------------------------------------------------------------------------
// uart_rx_bridge
// Receives UART bytes and posts each one into the shared data RAM through
// port 2 as a data word followed by a status word. The CPU polls the status
// word, reads the data word and acknowledges by writing the status address.
//   clock, rst : system clock / synchronous active-high reset
//   rx         : serial input, idle high
//   bus        : cpu_addr/cpu_we snooped, mem_addr/mem_din/mem_we driven
//   overrun    : sticky, a byte was dropped while the previous was pending
//   frame_err  : sticky, a frame had its stop bit low
// Status word: bit0 valid, bit1 overrun, bit2 frame error, bit3 parity error.
// Optional macro: UART_RX_PARITY_EN (8E1 frames, parity error in bit 3).
// ---------------------------------------------------------------------------
module uart_rx_bridge
    import uart_pkg::*;
#(
    parameter int          CLK_HZ         = 50_000_000,
    parameter int          BAUD           = 115200,
    parameter logic [11:0] RX_STATUS_ADDR = ADDR_RX_STATUS,
    parameter logic [11:0] RX_DATA_ADDR   = ADDR_RX_DATA
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    rx,
    uart_rx_bridge_if.master        bus,
    output logic                    overrun,
    output logic                    frame_err
);
    localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;

    logic       byte_done, stop_ok, par_ok;
    logic [7:0] data;

    uart_rx #(.DIVISOR(DIVISOR)) u_rx (
        .clock     (clock),
        .rst       (rst),
        .rx        (rx),
        .byte_done (byte_done),
        .data      (data),
        .stop_ok   (stop_ok),
        .par_ok    (par_ok)
    );

    mb_state_e   mb_q;
    logic        pending_q, overrun_q, frame_err_q, par_err_q;
    logic [11:0] mem_addr_q;
    logic [15:0] mem_din_q;
    logic        mem_we_q;

    logic ack;
    assign ack = bus.cpu_we && (bus.cpu_addr == RX_STATUS_ADDR);

    // Sticky state with this cycle's acknowledge already applied; every
    // decision below uses these so the ack always takes effect first.
    logic pending_d, overrun_d, frame_err_d, par_err_d;
    always_comb begin
        pending_d   = pending_q   & ~ack;
        overrun_d   = overrun_q   & ~ack;
        frame_err_d = frame_err_q & ~ack;
        par_err_d   = par_err_q   & ~ack;
    end

    // byte_done cannot recur while the mailbox is busy: a frame lasts at
    // least nine bit times and the mailbox returns to idle within four cycles.
    always_ff @(posedge clock) begin
        if (rst) begin
            mb_q        <= M_IDLE;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            mem_addr_q  <= RX_STATUS_ADDR;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            case (mb_q)
                M_IDLE: begin
                    if (byte_done) begin
                        frame_err_q <= frame_err_d | ~stop_ok;
                        par_err_q   <= par_err_d | ~par_ok;
                        if (!pending_d) begin
                            mb_q       <= M_DATA;
                            mem_addr_q <= RX_DATA_ADDR;
                            mem_din_q  <= {8'h00, data};
                            mem_we_q   <= 1'b1;
                        end else begin
                            // Previous byte still unread: drop this one and
                            // only refresh the status word.
                            mb_q       <= M_STAT;
                            overrun_q  <= 1'b1;
                            pending_q  <= 1'b1;
                            mem_addr_q <= RX_STATUS_ADDR;
                            mem_din_q  <= rx_status_word(par_err_d | ~par_ok,
                                                         frame_err_d | ~stop_ok,
                                                         1'b1);
                            mem_we_q   <= 1'b1;
                        end
                    end
                end
                M_DATA, M_WAIT: begin
                    if (mb_q == M_DATA && ack) begin
                        // CPU owns the status word this cycle; retry next.
                        mb_q <= M_WAIT;
                    end else begin
                        mb_q       <= M_STAT;
                        pending_q  <= 1'b1;
                        mem_addr_q <= RX_STATUS_ADDR;
                        mem_din_q  <= rx_status_word(par_err_d, frame_err_d, overrun_d);
                        mem_we_q   <= 1'b1;
                    end
                end
                M_STAT:  mb_q <= M_IDLE;
                default: mb_q <= M_IDLE;
            endcase
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: doc/uart_rx_bridge.md
# uart_rx_bridge

Serial receive path for the ONC-16 system. It samples the UART RX line, deframes 8N1 bytes and posts each byte into the shared data RAM through the RAM's second port, as a data word plus a status word. The CPU polls the RX status address, reads the RX data address, then acknowledges by writing the status address. It sits beside the transmit control logic in the top level and runs in the 50 MHz domain.

## Interface
- CLK_HZ, 50_000_000, clock frequency in Hz
- BAUD, 115200, line rate
- RX_STATUS_ADDR, 12'h802, RAM word holding RX status
- RX_DATA_ADDR, 12'h803, RAM word holding the received byte
- clock  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- cpu_addr  in  12  CPU data-memory address (port-1 address)
- cpu_we  in  1  CPU data-memory write enable
- mem_addr  out  12  RAM port-2 address
- mem_din  out  16  RAM port-2 write data
- mem_we  out  1  RAM port-2 write enable, one-cycle pulses
- overrun  out  1  sticky: byte dropped while previous one was pending
- frame_err  out  1  sticky: last frame had stop bit = 0

## Operation
- Line sampling: `rx` passes through a 2-flop synchronizer, reset value 1. DIVISOR = (CLK_HZ + BAUD/2) / BAUD. The bit counter width is $clog2(DIVISOR+1).
- Receive FSM states:
  - IDLE: a synchronized falling edge moves to START and loads half-bit count.
  - START: at half-bit, if the line is still 0 move to DATA; otherwise go back to IDLE with no write (glitch reject).
  - DATA: sample every DIVISOR cycles, 8 bits, LSB first.
  - STOP: sample once; the result is `frame_err = !stop`. Then raise `byte_done` for 1 cycle and return to IDLE. A frame with a framing error is still posted.
- Mailbox FSM states:
  - M_IDLE: on `byte_done`, if `pending`=0 go to M_DATA. If `pending`=1, drop the byte, set `overrun`, and go to M_STAT.
  - M_DATA: `mem_addr`=RX_DATA_ADDR, `mem_din`={8'h00, byte}, `mem_we`=1.
  - M_STAT: `mem_addr`=RX_STATUS_ADDR, `mem_din`={12'h0, par_err, frame_err, overrun, 1'b1}, `mem_we`=1. Set `pending`. Return to M_IDLE.
- Acknowledge: `cpu_we && cpu_addr==RX_STATUS_ADDR` clears `pending`, `overrun` and `frame_err`. The CPU's own write supplies the new status value.
- Port contention: if the ack condition is true in the cycle the mailbox would enter M_STAT, M_STAT is delayed 1 cycle. `mem_we` stays 0 for that cycle and the ack is applied first.
- Simultaneous ack and `byte_done`: the ack takes effect first, so the byte is accepted normally with no overrun.

## Timing
- Reset values: `mem_addr`=RX_STATUS_ADDR, `mem_din`=0, `mem_we`=0, `overrun`=0, `frame_err`=0. Both FSMs reset to IDLE and `pending`=0.
- Reset mid-frame aborts the frame and issues no RAM writes.
- Falling edge on `rx` to the data-bit-0 sample: 2 (synchronizer) + DIVISOR/2 + DIVISOR cycles.
- `byte_done` to data write (M_DATA): 1 cycle. Status write follows in the next cycle; there is no gap without contention.
- `mem_we` is asserted only in M_DATA and M_STAT, never for 2 consecutive writes to the same address.
- Back-to-back frames: a new falling edge is accepted in the cycle after the STOP sample.

## Configuration
- UART_RX_PARITY_EN defined: frames are 8E1. The parity bit is sampled between DATA and STOP (state PARITY). A mismatch sets status bit 3 (`par_err`), which is sticky until ack.
- UART_RX_PARITY_EN undefined: frames are 8N1, the PARITY state is absent and status bit 3 is always 0.

## Structure
- Shared package `uart_pkg`:
  - receive and mailbox FSM state encodings
  - status bit indices (VALID=0, OVR=1, FERR=2, PERR=3)
  - default address constants 12'h800–12'h803
- Sub-module `uart_rx` covers the synchronizer, baud counter and receive FSM. Its outputs are `byte_done`, `data[7:0]`, `stop_ok` and `par_ok`. The mailbox FSM lives in `uart_rx_bridge`.

## Test plan
With CLK_HZ=50_000_000 and BAUD=115200, DIVISOR=434.
- Send 0x55, 8N1 → write (0x803, 0x0055), then the next cycle write (0x802, 0x0001); `frame_err`=0.
- Send 0xA3 without ack, then 0x7E → exactly one write for the second byte: (0x802, 0x0003); RAM data stays 0x00A3; `overrun`=1.
- Send 0x41 with a stop bit of 0 → writes (0x803, 0x0041) and (0x802, 0x0005); `frame_err`=1. A CPU write to 0x802 clears it.
- Drive a 100-cycle low pulse on idle `rx` → no `mem_we` at any point; the next valid frame 0x12 is received correctly.
- Hold `cpu_we`=1, `cpu_addr`=0x802 in the cycle the status write is due → that cycle has `mem_we`=0; the status write happens 1 cycle later; `pending`=1 afterward.
- Assert `rst` during data bit 4 of 0xFF → no writes and outputs at reset values; a following frame 0x33 is posted normally.
